// File: rtl/equation_checker.sv
// equation_checker
//   One equation slot of the alarm puzzle. When Start rises the slot samples
//   the free-running Seed, derives two 4-bit operands and the expected result
//   for the configured operation, then grades user answers submitted on
//   DataIn with each rising edge of Go.
//
// Parameters
//   OP            0 = add, 1 = subtract (operands ordered so result >= 0),
//                 2 = multiply, 3 = add
//   MAX_ATTEMPTS  saturation value of the wrong-attempt counter (1..15)
//
// Ports
//   Clock     system clock
//   Resetn    asynchronous active-low reset
//   Start     high while this equation is active; low aborts to IDLE
//   Go        submit request level; rising edge detected internally
//   Seed      free-running value sampled when the equation is loaded
//   DataIn    user answer, unsigned
//   OperandA  displayed left operand
//   OperandB  displayed right operand
//   Correct   one-cycle pulse on a correct answer
//   Wrong     sticky flag, set by any incorrect submission
//   Attempts  count of incorrect submissions, saturating
//   Busy      high while loading, waiting for an answer or checking
//   Solved    high once the equation has been answered correctly
module equation_checker #(
  parameter int OP           = 0,
  parameter int MAX_ATTEMPTS = 15
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Go,
  input  logic [6:0] Seed,
  input  logic [7:0] DataIn,
  output logic [3:0] OperandA,
  output logic [3:0] OperandB,
  output logic       Correct,
  output logic       Wrong,
  output logic [3:0] Attempts,
  output logic       Busy,
  output logic       Solved
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_GO,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ATTEMPTS);

  state_t     state;
  state_t     state_next;
  logic       go_q;
  logic       go_rise;
  logic [7:0] answer;
  logic [7:0] expected;
  logic [3:0] raw_a;
  logic [3:0] raw_b;
  logic [3:0] load_a;
  logic [3:0] load_b;
  logic [7:0] expected_next;
  logic       match;

  assign go_rise = Go & ~go_q;
  assign match   = (answer == expected);

  // Operand derivation from the seed. Subtraction swaps the operands so the
  // displayed left operand is never smaller, keeping the answer non-negative.
  always_comb begin
    raw_a = Seed[3:0];
    raw_b = {1'b0, Seed[6:4]};
    if (OP == 1 && raw_b > raw_a) begin
      load_a = raw_b;
      load_b = raw_a;
    end else begin
      load_a = raw_a;
      load_b = raw_b;
    end
    case (OP)
      1:       expected_next = {4'd0, load_a} - {4'd0, load_b};
      2:       expected_next = {4'd0, load_a} * {4'd0, load_b};
      default: expected_next = {4'd0, load_a} + {4'd0, load_b};
    endcase
  end

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; Start low aborts from any active state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = LOAD;
      LOAD:    state_next = Start ? WAIT_GO : IDLE;
      WAIT_GO: begin
        if (!Start)       state_next = IDLE;
        else if (go_rise) state_next = CHECK;
      end
      CHECK: begin
        if (!Start)     state_next = IDLE;
        else if (match) state_next = DONE;
        else            state_next = WAIT_GO;
      end
      DONE:    if (!Start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    Busy   = (state == LOAD) || (state == WAIT_GO) || (state == CHECK);
    Solved = (state == DONE);
  end

  // Datapath registers. Every update is gated by Start so that an abort
  // leaves operands, Wrong and Attempts untouched and suppresses Correct.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      go_q     <= 1'b0;
      answer   <= 8'd0;
      expected <= 8'd0;
      OperandA <= 4'd0;
      OperandB <= 4'd0;
      Correct  <= 1'b0;
      Wrong    <= 1'b0;
      Attempts <= 4'd0;
    end else begin
      go_q    <= Go;
      Correct <= 1'b0;
      case (state)
        LOAD: begin
          if (Start) begin
            OperandA <= load_a;
            OperandB <= load_b;
            expected <= expected_next;
            Wrong    <= 1'b0;
            Attempts <= 4'd0;
          end
        end
        WAIT_GO: begin
          if (Start && go_rise) answer <= DataIn;
        end
        CHECK: begin
          if (Start) begin
            if (match) begin
              Correct <= 1'b1;
            end else begin
              Wrong <= 1'b1;
              if (Attempts < MAX_CNT) Attempts <= Attempts + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_equation_checker.sv
// tb_equation_checker
//   Scoreboard bench for equation_checker. Three slots are instantiated:
//   add (OP=0), subtract (OP=1) and multiply (OP=2, MAX_ATTEMPTS=3). Each
//   submission pushes the expected output snapshot with the cycle it is due;
//   a monitor on the falling edge pops due entries and compares them, and
//   also flags any Correct pulse the scoreboard did not predict.
module tb_equation_checker;

  logic       Clock;
  logic       Resetn;
  logic [2:0] start;
  logic       Go;
  logic [6:0] Seed;
  logic [7:0] DataIn;

  logic [3:0] op_a     [3];
  logic [3:0] op_b     [3];
  logic       correct  [3];
  logic       wrong    [3];
  logic [3:0] attempts [3];
  logic       busy     [3];
  logic       solved   [3];

  typedef struct {
    int          idx;
    int          due;
    logic [15:0] exp_vec;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  equation_checker #(.OP(0), .MAX_ATTEMPTS(15)) u_add (
    .Clock(Clock), .Resetn(Resetn), .Start(start[0]), .Go(Go), .Seed(Seed),
    .DataIn(DataIn), .OperandA(op_a[0]), .OperandB(op_b[0]),
    .Correct(correct[0]), .Wrong(wrong[0]), .Attempts(attempts[0]),
    .Busy(busy[0]), .Solved(solved[0])
  );

  equation_checker #(.OP(1), .MAX_ATTEMPTS(15)) u_sub (
    .Clock(Clock), .Resetn(Resetn), .Start(start[1]), .Go(Go), .Seed(Seed),
    .DataIn(DataIn), .OperandA(op_a[1]), .OperandB(op_b[1]),
    .Correct(correct[1]), .Wrong(wrong[1]), .Attempts(attempts[1]),
    .Busy(busy[1]), .Solved(solved[1])
  );

  equation_checker #(.OP(2), .MAX_ATTEMPTS(3)) u_mul (
    .Clock(Clock), .Resetn(Resetn), .Start(start[2]), .Go(Go), .Seed(Seed),
    .DataIn(DataIn), .OperandA(op_a[2]), .OperandB(op_b[2]),
    .Correct(correct[2]), .Wrong(wrong[2]), .Attempts(attempts[2]),
    .Busy(busy[2]), .Solved(solved[2])
  );

  // Free-running clock, 10 time-unit period
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Rising-edge counter used to timestamp scoreboard entries
  always @(posedge Clock) cyc <= cyc + 1;

  // Packs an output snapshot: {Correct, Wrong, Attempts, Solved, Busy, A, B}
  function automatic logic [15:0] mk(input logic c, input logic w, input logic [3:0] at,
                                     input logic s, input logic b,
                                     input logic [3:0] a, input logic [3:0] bb);
    return {c, w, at, s, b, a, bb};
  endfunction

  function automatic logic [15:0] obs(input int i);
    return {correct[i], wrong[i], attempts[i], solved[i], busy[i], op_a[i], op_b[i]};
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s dut=%0d got={C,W,Att,S,B,A,B}=%h expected=%h t=%0t",
               name, idx, actual, expected, $time);
    end
  endtask

  // Monitor: compare due scoreboard entries and catch unpredicted Correct pulses
  always @(negedge Clock) begin
    bit pulse_ok [3];
    for (int i = 0; i < 3; i++) pulse_ok[i] = 1'b0;
    while (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.exp_vec[15]) pulse_ok[e.idx] = 1'b1;
      checkOutput("scoreboard", e.idx, obs(e.idx), e.exp_vec);
    end
    for (int i = 0; i < 3; i++) begin
      if (correct[i] && !pulse_ok[i])
        checkOutput("spurious_correct", i, {15'd0, correct[i]}, 16'd0);
    end
  end

  // One Go press with answer `data`; `after` is the snapshot expected the
  // cycle after CHECK. DataIn is scrambled while CHECK is in progress.
  task automatic applyStimulus(input int idx, input logic [7:0] data,
                               input logic [15:0] after, input bit is_correct);
    exp_t e;
    DataIn = data;
    Go     = 1'b1;
    e.idx = idx; e.due = cyc + 2; e.exp_vec = after;
    q.push_back(e);
    if (is_correct) begin
      e.due = cyc + 3; e.exp_vec = after & 16'h7FFF;
      q.push_back(e);
    end
    @(negedge Clock);
    Go     = 1'b0;
    DataIn = ~data;
    repeat (3) @(negedge Clock);
  endtask

  task automatic startSlot(input int idx, input logic [6:0] seed);
    Seed       = seed;
    start[idx] = 1'b1;
    repeat (2) @(negedge Clock);
  endtask

  task automatic stopSlot(input int idx);
    start[idx] = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  initial begin
    Resetn = 1'b1;
    start  = 3'b000;
    Go     = 1'b0;
    Seed   = 7'd0;
    DataIn = 8'd0;
    #1 Resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) checkOutput("reset", i, obs(i), 16'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // Add, first-try correct: 6 + 5 = 11
    startSlot(0, 7'b101_0110);
    checkOutput("add_load", 0, obs(0), mk(0, 0, 4'd0, 0, 1, 4'd6, 4'd5));
    applyStimulus(0, 8'd11, mk(1, 0, 4'd0, 1, 0, 4'd6, 4'd5), 1'b1);
    stopSlot(0);
    checkOutput("add_idle_hold", 0, obs(0), mk(0, 0, 4'd0, 0, 0, 4'd6, 4'd5));

    // Add, wrong then correct; Wrong stays sticky
    startSlot(0, 7'b101_0110);
    checkOutput("add_reload", 0, obs(0), mk(0, 0, 4'd0, 0, 1, 4'd6, 4'd5));
    applyStimulus(0, 8'd12, mk(0, 1, 4'd1, 0, 1, 4'd6, 4'd5), 1'b0);
    applyStimulus(0, 8'd11, mk(1, 1, 4'd1, 1, 0, 4'd6, 4'd5), 1'b1);
    stopSlot(0);

    // Subtract with swap: A=2, B=7 -> 7 - 2 = 5; 0xFB is wrong
    startSlot(1, 7'b111_0010);
    checkOutput("sub_swap", 1, obs(1), mk(0, 0, 4'd0, 0, 1, 4'd7, 4'd2));
    applyStimulus(1, 8'hFB, mk(0, 1, 4'd1, 0, 1, 4'd7, 4'd2), 1'b0);
    applyStimulus(1, 8'd5, mk(1, 1, 4'd1, 1, 0, 4'd7, 4'd2), 1'b1);
    stopSlot(1);

    // Multiply 15 * 7 = 105; Go held high for 10 cycles counts once
    startSlot(2, 7'b111_1111);
    checkOutput("mul_load", 2, obs(2), mk(0, 0, 4'd0, 0, 1, 4'd15, 4'd7));
    begin
      exp_t e;
      DataIn = 8'd0;
      Go     = 1'b1;
      e.idx = 2; e.due = cyc + 2; e.exp_vec = mk(0, 1, 4'd1, 0, 1, 4'd15, 4'd7);
      q.push_back(e);
      repeat (10) @(negedge Clock);
      checkOutput("go_held", 2, obs(2), mk(0, 1, 4'd1, 0, 1, 4'd15, 4'd7));
      Go = 1'b0;
      repeat (2) @(negedge Clock);
    end
    // Saturation at MAX_ATTEMPTS=3 after four wrong presses
    applyStimulus(2, 8'd1, mk(0, 1, 4'd2, 0, 1, 4'd15, 4'd7), 1'b0);
    applyStimulus(2, 8'd2, mk(0, 1, 4'd3, 0, 1, 4'd15, 4'd7), 1'b0);
    applyStimulus(2, 8'd3, mk(0, 1, 4'd3, 0, 1, 4'd15, 4'd7), 1'b0);
    applyStimulus(2, 8'd105, mk(1, 1, 4'd3, 1, 0, 4'd15, 4'd7), 1'b1);
    // Restart with a fresh seed: A=4, B=3, flags cleared
    stopSlot(2);
    startSlot(2, 7'b011_0100);
    checkOutput("mul_restart", 2, obs(2), mk(0, 0, 4'd0, 0, 1, 4'd4, 4'd3));

    // Async reset mid WAIT_GO after two wrong attempts
    applyStimulus(2, 8'd0, mk(0, 1, 4'd1, 0, 1, 4'd4, 4'd3), 1'b0);
    applyStimulus(2, 8'd1, mk(0, 1, 4'd2, 0, 1, 4'd4, 4'd3), 1'b0);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("async_reset", 2, obs(2), 16'd0);
    start[2] = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // Start dropped during CHECK: correct answer must not pulse Correct
    startSlot(0, 7'b101_0110);
    DataIn = 8'd11;
    Go     = 1'b1;
    @(negedge Clock);
    start[0] = 1'b0;
    Go       = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("abort_check", 0, obs(0), mk(0, 0, 4'd0, 0, 0, 4'd6, 4'd5));

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge Clock);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/equation_checker.md
Name: equation_checker

Overview:
- Downstream stage of the alarm's top control FSM; one instance per equation slot.
- When its start input goes high, it latches a free-running seed and derives two operands from it.
- It then accepts user answers on switch data, one per Go press, and compares each against the computed result.
- It reports a one-cycle correct pulse, a sticky wrong flag and an attempt count back to the controller and to the VGA side.

Parameters:
- OP, default 0: operation; 0 = add, 1 = subtract (non-negative), 2 = multiply; 3 behaves as add.
- MAX_ATTEMPTS, default 15: saturation value of the attempt counter; legal range 1..15.

Ports:
- Clock  input  1  system clock (CLOCK_50 domain).
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  level from the controller; high while this equation is active.
- Go  input  1  submit request, active-high level (already inverted from KEY); rising edge detected internally.
- Seed  input  7  free-running counter value, sampled in LOAD.
- DataIn  input  8  user answer, unsigned.
- OperandA  output  4  displayed left operand.
- OperandB  output  4  displayed right operand.
- Correct  output  1  one-cycle pulse on a correct answer.
- Wrong  output  1  sticky; set by any incorrect submission.
- Attempts  output  4  count of incorrect submissions, saturating.
- Busy  output  1  high in LOAD, WAIT_GO and CHECK.
- Solved  output  1  level, high in DONE.

Behaviour:
- Reset (async, Resetn=0):
  - State goes to IDLE.
  - OperandA, OperandB, Correct, Wrong, Attempts, Busy and Solved all go to 0.
  - Internal go_q and Answer go to 0.
- State register, all transitions on the Clock rising edge:
  - IDLE: go to LOAD when Start=1.
  - LOAD (one cycle):
    - Raw operands: A = Seed[3:0], B = {1'b0, Seed[6:4]}.
    - If OP=1 and B>A, swap them so that OperandA>=OperandB.
    - Register OperandA and OperandB.
    - Compute Expected as an 8-bit value: A+B (max 22), A-B (min 0), or A*B (max 105). No overflow is possible.
    - Clear Wrong and Attempts; go to WAIT_GO.
  - WAIT_GO:
    - go_q tracks Go every cycle, in all states.
    - On Go=1 and go_q=0, latch Answer<=DataIn and go to CHECK.
    - Holding Go high yields exactly one submission; the next submission needs Go to drop for at least one cycle.
  - CHECK (one cycle):
    - If Answer==Expected: Correct<=1 for exactly one cycle; go to DONE.
    - Otherwise: Wrong<=1; Attempts<=Attempts+1, saturating at MAX_ATTEMPTS; return to WAIT_GO.
  - DONE: Solved=1; operands are held; go to IDLE when Start=0.
- Start low in LOAD, WAIT_GO or CHECK aborts to IDLE on the next edge:
  - A pending CHECK does not emit Correct.
  - Operands, Wrong and Attempts hold their values.
  - Busy drops.
- Latency:
  - Go is first sampled high at edge t, with DataIn sampled at that edge.
  - CHECK occupies t to t+1.
  - Correct is high from edge t+1 to edge t+2.
  - Solved is high from edge t+1.
- Go already high when WAIT_GO is entered: counts as a submission only if go_q=0, i.e. Go was low in the previous cycle.
- DataIn is ignored outside the submission edge; bit changes during CHECK have no effect.
- Re-entering via Start 0→1 takes a fresh seed and clears Wrong and Attempts.
- Busy = state in {LOAD, WAIT_GO, CHECK}.

Test Plan:
- OP=0, Seed=7'b101_0110, Start=1 → OperandA=6, OperandB=5. Then DataIn=11, pulse Go → Correct high for exactly 1 cycle at t+1, Solved=1, Wrong=0, Attempts=0.
- OP=0, same seed:
  - DataIn=12 with a Go pulse → Wrong=1, Attempts=1, state back in WAIT_GO, no Correct.
  - Then DataIn=11 with a Go pulse → Correct pulse; Wrong stays 1.
- OP=1, Seed=7'b111_0010 (A=2, B=7) → OperandA=7, OperandB=2; DataIn=5 → Correct. DataIn=8'hFB (−5) → wrong.
- OP=2, Seed=7'b111_1111 → operands 15 and 7; DataIn=105 → Correct. Also hold Go high for 10 cycles with a wrong DataIn → Attempts increments by exactly 1.
- MAX_ATTEMPTS=3: four wrong presses → Attempts=3 (saturated). Then Start low/high → Attempts=0, Wrong=0, new operands from the current Seed.
- Resetn low mid-WAIT_GO (after 2 wrong attempts) → all outputs 0 immediately without waiting for a clock edge. Start low in CHECK → no Correct, return to IDLE.
